// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port controller.
//   DATA_W / ADDR_W / NREG : register-file geometry (NREG == 2**ADDR_W)
//   REQ_ALU / REQ_LD       : requester indices into request/grant vectors
//   rr_pri_e               : which requester wins the next tie
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } rr_pri_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a one-bit priority pointer.
//   CLK, RESET : clock, synchronous active-high reset
//   req[1:0]   : request vector
//   gnt[1:0]   : one-hot (or zero) combinational grant; forced to 0 in reset
// The pointer moves only on a grant, so idle cycles keep the current priority.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_pri_e pri;

  always_comb begin
    gnt = '0;
    if (!RESET) begin
      if (req[0] && (!req[1] || pri == PRI_REQ0))
        gnt[0] = 1'b1;
      else if (req[1])
        gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      pri <= PRI_REQ0;
    else if (gnt[0])
      pri <= PRI_REQ1;
    else if (gnt[1])
      pri <= PRI_REQ0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the register file.
//   CLK, RESET                    : clock, synchronous active-high reset
//   issue_valid/issue_we/issue_rd : instruction presented by issue stage
//   rs, rt                        : its source registers
//   stall                         : RAW/WAW hazard, instruction must wait
//   reqN_valid/rd/data, reqN_ready: writeback requesters (0 = ALU, 1 = load)
//   wreg, rd, WriteData           : registered register-file write port
//   busy                          : per-register pending-write scoreboard
//   err                           : sticky protocol error
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREG   = regfile_pkg::NREG
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wreg,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] WriteData,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            issue_set;
  logic [NREG-1:0] busy_nxt;
  logic            pend0, pend1;
  logic            err_evt;

  assign req[REQ_ALU] = req0_valid;
  assign req[REQ_LD]  = req1_valid;

  rr_arbiter2 u_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .req   (req),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[REQ_ALU];
  assign req1_ready = gnt[REQ_LD];

  always_comb begin
    stall = 1'b0;
    if (!RESET && issue_valid)
      stall = busy[rs] | busy[rt] | (issue_we & busy[issue_rd]);
  end

  assign issue_set = issue_valid & issue_we & ~stall;

  // Clear applied before set so a same-edge set on the retiring register wins.
  always_comb begin
    busy_nxt = busy;
    if (wreg)
      busy_nxt[rd] = 1'b0;
    if (issue_set)
      busy_nxt[issue_rd] = 1'b1;
  end

  // pendN remembers a request left waiting at the last edge, so a valid that
  // falls before its grant can be caught on the next edge.
  always_comb begin
    err_evt = 1'b0;
    if (gnt[REQ_ALU] && !busy[req0_rd]) err_evt = 1'b1;
    if (gnt[REQ_LD]  && !busy[req1_rd]) err_evt = 1'b1;
    if (pend0 && !req0_valid)           err_evt = 1'b1;
    if (pend1 && !req1_valid)           err_evt = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wreg      <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
      busy      <= '0;
      err       <= 1'b0;
      pend0     <= 1'b0;
      pend1     <= 1'b0;
    end else begin
      wreg  <= |gnt;
      busy  <= busy_nxt;
      pend0 <= req0_valid & ~gnt[REQ_ALU];
      pend1 <= req1_valid & ~gnt[REQ_LD];
      if (err_evt)
        err <= 1'b1;
      if (gnt[REQ_ALU]) begin
        rd        <= req0_rd;
        WriteData <= req0_data;
      end else if (gnt[REQ_LD]) begin
        rd        <= req1_rd;
        WriteData <= req1_data;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port controller for the 16x16 register file.
- Shares the single write port (wreg/rd/WriteData) between two writeback requesters: req0 (ALU) and req1 (load unit). Arbitration is round-robin, with a valid/ready handshake on each requester.
- Keeps a per-register busy scoreboard. Issue logic sets a bit when an instruction that will write that register is issued. The bit clears when the register file actually writes it.
- Drives a stall to the issue stage on RAW and WAW hazards. Sits between decode/issue, the execution units and the register file.

Parameters:
- DATA_W, 16, data width of WriteData and reqN_data.
- ADDR_W, 4, register address width.
- NREG, 16, number of registers; must equal 2**ADDR_W.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous reset, active-high.
- issue_valid  input  1  issue stage presents an instruction this cycle.
- issue_we  input  1  presented instruction will write a register.
- issue_rd  input  ADDR_W  destination of presented instruction.
- rs  input  ADDR_W  source register 1 of presented instruction.
- rt  input  ADDR_W  source register 2 of presented instruction.
- stall  output  1  presented instruction must not issue this cycle.
- req0_valid  input  1  ALU writeback request.
- req0_rd  input  ADDR_W  ALU writeback destination.
- req0_data  input  DATA_W  ALU writeback data.
- req0_ready  output  1  ALU request accepted this cycle.
- req1_valid, req1_rd, req1_data, req1_ready  same as req0, for the load unit.
- wreg  output  1  register-file write enable (registered).
- rd  output  ADDR_W  register-file write address (registered).
- WriteData  output  DATA_W  register-file write data (registered).
- busy  output  NREG  scoreboard state, one bit per register.
- err  output  1  sticky protocol error flag.

Behaviour:
Reset
- RESET=1 at a rising edge clears: wreg, rd, WriteData, busy, err.
- The round-robin pointer is set so req0 wins the next tie.
- While RESET is high, all ready outputs and stall are 0.
- A reset in the middle of operation drops any in-flight grant; the register file is not written.

Arbitration
- Combinational grant, one per cycle:
  - Only one requester valid: that one gets ready=1.
  - Both valid: the requester not granted last gets ready=1.
  - After reset, req0 wins the first tie.
- The pointer updates only when a grant occurs; idle cycles do not move it.
- Handshake: once reqN_valid rises, reqN_valid, rd and data must be held until reqN_ready=1. The transfer occurs on the edge where valid&ready=1. A requester never sees ready without valid.

Write port
- Latency is one cycle: the accepted request appears on wreg=1/rd/WriteData in the cycle after the handshake edge.
- wreg=0 in any cycle following an edge with no grant. rd and WriteData hold their last value.
- Sustained throughput is one write per cycle; with both requesters valid, grants alternate 0,1,0,1.

Scoreboard
- Set: busy[issue_rd] is set at an edge where issue_valid & issue_we & !stall.
- Clear: busy[rd] clears at an edge where wreg=1, i.e. the same edge the register file captures WriteData. The register file therefore holds the new value in the first cycle busy reads 0, and no forwarding is needed.
- Same register set and cleared at one edge: set wins.
- Hazard check: stall = issue_valid & (busy[rs] | busy[rt] | (issue_we & busy[issue_rd])).
  - Checks are combinational on current busy.
  - rs==rt is allowed.
  - Register 0 is tracked like any other register.

Error flag
- err sets and stays set until RESET when either:
  - a handshake completes for a register whose busy bit is 0; or
  - reqN_valid drops without ready.
- The write still proceeds in both cases.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W, ADDR_W and NREG constants.
  - Requester index constants REQ_ALU=0 and REQ_LD=1.
- One natural sub-module, rr_arbiter2: two-input round-robin grant with pointer, purely request/grant. The scoreboard and write-port register stay in the top module.

Test Plan:
- Reset and idle:
  - Hold RESET 2 cycles with all valids high.
  - Required: ready=0, stall=0, wreg=0, busy=0, err=0.
  - Release RESET: req0_ready=1 in the first cycle.
- Single ALU writeback:
  - Issue issue_rd=3, issue_we=1; busy[3]=1 next cycle.
  - req0 {rd=3, data=16'hABCD} is accepted.
  - Next cycle: wreg=1, rd=3, WriteData=16'hABCD.
  - The following cycle: busy[3]=0.
- Contention:
  - busy[5], busy[6] set; req0 {5, 16'h0011} and req1 {6, 16'h0022} raised together.
  - req0 is granted first; req1 is granted the next cycle.
  - Writes appear on consecutive cycles in the order 5 then 6.
  - A repeat tie after that grants req0 (pointer has rotated back).
- RAW/WAW stall:
  - With busy[7]=1, present rs=7 → stall=1; present rt=7 → stall=1; present issue_rd=7 with issue_we=1 → stall=1.
  - With busy[7]=1, present rs=2, rt=4, issue_rd=9 → stall=0, and busy[9] sets.
  - stall drops in the cycle after wreg=1, rd=7.
- Set/clear collision:
  - Issue a new write to r4 at the same edge wreg=1, rd=4 occurs.
  - Required: busy[4] remains 1.
- Error and mid-operation reset:
  - Handshake req1 to rd=12 with busy[12]=0 → err=1 and the write still occurs.
  - Assert RESET in the cycle after a grant → wreg=0 next cycle, err=0, busy=0.
